// File: rtl/nf_uart_rx.sv
// nf_uart_rx: 8N1 UART receiver, runtime baud via comp; optional NF_UART_RX_SYNC_EN input synchronizer
module nf_uart_rx (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rec_en,
  input  logic [15:0] comp,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_val_set,
  input  logic        uart_rx
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic        line;
  logic        rx_r;
  logic        rx_p;
  logic        fall;
  logic        hit;
  logic        good;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
`ifdef NF_UART_RX_SYNC_EN
  logic [1:0] sync;
  // two-flop metastability guard on the asynchronous line
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync <= 2'b11;
    else sync <= {sync[0], uart_rx};
  assign line = sync[1];
`else
  assign line = uart_rx;
`endif
  assign fall = rx_p & ~rx_r;
  assign hit  = cnt == (state == START ? comp >> 1 : comp - 16'd1);
  assign good = rec_en && state == STOP && hit && rx_r;
  // registered line plus its previous value for start-edge detection
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {rx_r, rx_p} <= 2'b11;
    else {rx_r, rx_p} <= {line, rx_r};
  // frame sequencer: half-bit start check, then one mid-bit sample per bit period
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else if (!rec_en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:
          if (fall) begin
            cnt   <= '0;
            state <= START;
          end
        START:
          if (hit) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_r ? IDLE : DATA;
          end else cnt <= cnt + 16'd1;
        DATA:
          if (hit) begin
            cnt        <= '0;
            shift[idx] <= rx_r;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 16'd1;
        default:
          if (hit) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + 16'd1;
      endcase
    end
  // byte hand-off; a good stop bit beats a simultaneous clear
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (good) begin
      rx_data  <= shift;
      rx_valid <= 1'b1;
    end else if (rx_val_set) rx_valid <= 1'b0;
endmodule

// File: tb/tb_nf_uart_rx.sv
// tb_nf_uart_rx: table-driven and randomized bench for nf_uart_rx
module tb_nf_uart_rx;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rec_en = 1'b1;
  logic [15:0] comp = 16'd434;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_val_set = 1'b0;
  logic        uart_rx = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    int unsigned cmp;
    bit          en;
    logic [7:0]  d;
    bit          ok;
    bit          clr;
    logic [7:0]  xd;
    bit          xv;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] exp_d;
  bit         exp_v;
  nf_uart_rx dut (
    .clk(clk), .resetn(resetn), .rec_en(rec_en), .comp(comp),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_val_set(rx_val_set), .uart_rx(uart_rx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask
  task automatic drive_bit(input logic b, input int unsigned n);
    uart_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input bit ok);
    drive_bit(1'b0, comp);
    for (int i = 0; i < 8; i++) drive_bit(d[i], comp);
    drive_bit(ok, comp);
    if (!ok) drive_bit(1'b1, comp);
  endtask
  task automatic clear_valid(input string nm);
    rx_val_set = 1'b1;
    @(posedge clk);
    #1;
    rx_val_set = 1'b0;
    chk(nm, rx_valid, 0);
  endtask
  initial begin
    string s;
    s = "Hello World!";
    tbl.push_back('{434, 1'b1, 8'h48, 1'b1, 1'b1, 8'h48, 1'b1});
    for (int i = 0; i < s.len(); i++) tbl.push_back('{52, 1'b1, s[i], 1'b1, 1'b1, s[i], 1'b1});
    tbl.push_back('{52, 1'b0, 8'h55, 1'b1, 1'b0, 8'h21, 1'b0});
    tbl.push_back('{52, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1});
    tbl.push_back('{52, 1'b1, 8'h81, 1'b0, 1'b0, 8'hA5, 1'b0});
    tbl.push_back('{52, 1'b1, 8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", rx_data, 0);
    chk("reset_valid", rx_valid, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      comp = 16'(tbl[i].cmp);
      rec_en = tbl[i].en;
      send_frame(tbl[i].d, tbl[i].ok);
      rec_en = 1'b1;
      chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].xd);
      chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].xv);
      if (tbl[i].clr) clear_valid($sformatf("tbl%0d_clear", i));
    end
    comp = 16'd434;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 868);
    chk("glitch_data", rx_data, 8'h7E);
    chk("glitch_valid", rx_valid, 1);
    clear_valid("glitch_clear");
    send_frame(8'h3C, 1'b1);
    chk("post_glitch_data", rx_data, 8'h3C);
    chk("post_glitch_valid", rx_valid, 1);
    comp = 16'd52;
    drive_bit(1'b0, comp);
    for (int i = 0; i < 4; i++) drive_bit(i[0], comp);
    resetn = 1'b0;
    #1;
    chk("midreset_data", rx_data, 0);
    chk("midreset_valid", rx_valid, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive_bit(1'b1, 104);
    send_frame(8'hF0, 1'b1);
    chk("after_reset_data", rx_data, 8'hF0);
    chk("after_reset_valid", rx_valid, 1);
    exp_d = 8'hF0;
    exp_v = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [7:0] d;
      bit ok;
      bit en;
      d = 8'($urandom);
      ok = $urandom_range(99, 0) >= 15;
      en = $urandom_range(9, 0) != 0;
      comp = 16'($urandom_range(40, 16));
      rec_en = en;
      send_frame(d, ok);
      rec_en = 1'b1;
      if (en && ok) begin
        exp_d = d;
        exp_v = 1'b1;
      end
      chk($sformatf("rnd%0d_data", k), rx_data, exp_d);
      chk($sformatf("rnd%0d_valid", k), rx_valid, exp_v);
      if ($urandom_range(1, 0) == 1) begin
        clear_valid($sformatf("rnd%0d_clear", k));
        exp_v = 1'b0;
      end
      drive_bit(1'b1, 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
